// File: rtl/peak_error_pkg.sv
// Shared types, tdata field map and error saturation for peak_error_axis_tx.
package peak_error_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CAPTURED = 2'd2
    } state_t;

    localparam int CNT_W  = 24;
    localparam int ERR_W  = 16;
    localparam int DIFF_W = CNT_W + 1;
    localparam int IDX_W  = 14;

    localparam int ERR_LSB     = 0;
    localparam int NO_PEAK_BIT = 16;
    localparam int DROP_BIT    = 17;
    localparam int IDX_LSB     = 18;

    localparam logic signed [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic signed [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};

    localparam logic signed [DIFF_W-1:0] ERR_MAX_X = {{(DIFF_W-ERR_W){1'b0}}, ERR_MAX};
    localparam logic signed [DIFF_W-1:0] ERR_MIN_X = {{(DIFF_W-ERR_W){1'b1}}, ERR_MIN};

    function automatic logic [ERR_W-1:0] saturate(input logic signed [DIFF_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v > ERR_MAX_X) begin
            r = ERR_MAX;
        end else if (v < ERR_MIN_X) begin
            r = ERR_MIN;
        end else begin
            r = v[ERR_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/peak_edge_qualifier.sv
// Rising-edge detector on the differentiator state, producing a one-cycle peak pulse.
// Optional two-sample debounce selected by PEAK_ERR_DEBOUNCE_EN.
module peak_edge_qualifier (
    input  logic clk,
    input  logic rst,
    input  logic diff_state_in,
    output logic peak_pulse
);

    logic s1_q, s1_d;

`ifdef PEAK_ERR_DEBOUNCE_EN
    logic s2_q, s2_d;

    // Require two consecutive high samples following a low sample.
    always_comb begin
        s1_d       = diff_state_in;
        s2_d       = s1_q;
        peak_pulse = diff_state_in & s1_q & ~s2_q;
    end

    // Sample history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
`else
    // Single-sample rising edge.
    always_comb begin
        s1_d       = diff_state_in;
        peak_pulse = diff_state_in & ~s1_q;
    end

    // Previous-sample register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
        end
    end
`endif

endmodule

// File: rtl/peak_error_axis_tx.sv
// Timestamps the first peak per scan, subtracts the setpoint and streams the saturated
// error over AXI4-Stream. PEAK_ERR_DEBOUNCE_EN enables the two-sample edge debounce.
module peak_error_axis_tx
    import peak_error_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 24,
    parameter int ERR_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        diff_state_in,
    input  logic                        scan_sync,
    input  logic [CNT_WIDTH-1:0]        setpoint,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
    output logic                        M_AXIS_OUT_tvalid,
    input  logic                        M_AXIS_OUT_tready,
    output logic                        overflow_out
);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   peak_s;

    logic                   cap_valid_q, cap_valid_d;
    logic                   cap_nopeak_q, cap_nopeak_d;
    logic [CNT_WIDTH-1:0]   cap_phase_q, cap_phase_d;
    logic [CNT_WIDTH-1:0]   cap_setpoint_q, cap_setpoint_d;
    logic [IDX_W-1:0]       cap_idx_q, cap_idx_d;

    logic                   res_valid_q, res_valid_d;
    logic                   res_nopeak_q, res_nopeak_d;
    logic [ERR_WIDTH-1:0]   res_err_q, res_err_d;
    logic [IDX_W-1:0]       res_idx_q, res_idx_d;
    logic signed [CNT_WIDTH:0] diff_s;

    logic                        out_valid_q, out_valid_d;
    logic [AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                        drop_pending_q, drop_pending_d;
    logic                        overflow_q, overflow_d;
    logic                        accept_s;

    peak_edge_qualifier u_edge (
        .clk           (clk),
        .rst           (rst),
        .diff_state_in (diff_state_in),
        .peak_pulse    (peak_s)
    );

    // Scan FSM, phase counter and scan index; scan_sync has priority over a peak.
    always_comb begin
        state_d        = state_q;
        cap_valid_d    = 1'b0;
        cap_nopeak_d   = cap_nopeak_q;
        cap_phase_d    = cap_phase_q;
        cap_setpoint_d = cap_setpoint_q;
        cap_idx_d      = cap_idx_q;
        if (scan_sync) begin
            cnt_d = {CNT_WIDTH{1'b0}};
            idx_d = idx_q + 14'd1;
        end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end else begin
            cnt_d = cnt_q;
            idx_d = idx_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (scan_sync) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (scan_sync) begin
                    cap_valid_d  = 1'b1;
                    cap_nopeak_d = 1'b1;
                    cap_idx_d    = idx_q;
                end else if (peak_s) begin
                    cap_valid_d    = 1'b1;
                    cap_nopeak_d   = 1'b0;
                    cap_phase_d    = cnt_q;
                    cap_setpoint_d = setpoint;
                    cap_idx_d      = idx_q;
                    state_d        = ST_CAPTURED;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURED: begin
                if (scan_sync) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_CAPTURED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Subtract/saturate stage and single-entry output holding register with drop tracking.
    always_comb begin
        diff_s       = $signed({1'b0, cap_phase_q}) - $signed({1'b0, cap_setpoint_q});
        res_valid_d  = cap_valid_q;
        res_nopeak_d = res_nopeak_q;
        res_err_d    = res_err_q;
        res_idx_d    = res_idx_q;
        if (cap_valid_q) begin
            res_nopeak_d = cap_nopeak_q;
            res_err_d    = cap_nopeak_q ? {ERR_WIDTH{1'b0}} : saturate(diff_s);
            res_idx_d    = cap_idx_q;
        end else begin
            res_nopeak_d = res_nopeak_q;
        end

        accept_s       = out_valid_q & M_AXIS_OUT_tready;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        drop_pending_d = drop_pending_q;
        overflow_d     = overflow_q;
        if (res_valid_q) begin
            if (!out_valid_q || accept_s) begin
                out_valid_d                          = 1'b1;
                out_data_d[ERR_LSB +: ERR_WIDTH]     = res_err_q;
                out_data_d[NO_PEAK_BIT]              = res_nopeak_q;
                out_data_d[DROP_BIT]                 = drop_pending_q;
                out_data_d[IDX_LSB +: IDX_W]         = res_idx_q;
                drop_pending_d                       = 1'b0;
            end else begin
                overflow_d     = 1'b1;
                drop_pending_d = 1'b1;
            end
        end else if (accept_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // All state registers; reset returns the block to IDLE and discards any held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {CNT_WIDTH{1'b0}};
            idx_q          <= {IDX_W{1'b0}};
            cap_valid_q    <= 1'b0;
            cap_nopeak_q   <= 1'b0;
            cap_phase_q    <= {CNT_WIDTH{1'b0}};
            cap_setpoint_q <= {CNT_WIDTH{1'b0}};
            cap_idx_q      <= {IDX_W{1'b0}};
            res_valid_q    <= 1'b0;
            res_nopeak_q   <= 1'b0;
            res_err_q      <= {ERR_WIDTH{1'b0}};
            res_idx_q      <= {IDX_W{1'b0}};
            out_valid_q    <= 1'b0;
            out_data_q     <= {AXIS_TDATA_WIDTH{1'b0}};
            drop_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            cap_valid_q    <= cap_valid_d;
            cap_nopeak_q   <= cap_nopeak_d;
            cap_phase_q    <= cap_phase_d;
            cap_setpoint_q <= cap_setpoint_d;
            cap_idx_q      <= cap_idx_d;
            res_valid_q    <= res_valid_d;
            res_nopeak_q   <= res_nopeak_d;
            res_err_q      <= res_err_d;
            res_idx_q      <= res_idx_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            drop_pending_q <= drop_pending_d;
            overflow_q     <= overflow_d;
        end
    end

    assign M_AXIS_OUT_tdata  = out_data_q;
    assign M_AXIS_OUT_tvalid = out_valid_q;
    assign overflow_out      = overflow_q;

endmodule

// File: tb/tb_peak_error_axis_tx.sv
// Scoreboard bench for peak_error_axis_tx: expected words are queued when stimulus is
// driven and compared when the DUT hands a word over (tvalid && tready).
`timescale 1ns/1ps
module tb_peak_error_axis_tx;

`ifdef PEAK_ERR_DEBOUNCE_EN
    localparam int DB = 1;
`else
    localparam int DB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        diff_state_in;
    logic        scan_sync;
    logic [23:0] setpoint;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        overflow_out;

    int          checks = 0;
    int          errors = 0;
    int          sync_cnt = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;
    logic [31:0] held;

    peak_error_axis_tx dut (
        .clk               (clk),
        .rst               (rst),
        .diff_state_in     (diff_state_in),
        .scan_sync         (scan_sync),
        .setpoint          (setpoint),
        .M_AXIS_OUT_tdata  (tdata),
        .M_AXIS_OUT_tvalid (tvalid),
        .M_AXIS_OUT_tready (tready),
        .overflow_out      (overflow_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkword(input int idx, input logic np, input logic drop,
                                           input longint phase, input longint sp);
        longint      e;
        logic [15:0] ef;
        logic [13:0] ix;
        ix = idx[13:0];
        e  = phase - sp;
        if (e > 32767)  e = 32767;
        if (e < -32768) e = -32768;
        ef = np ? 16'h0000 : 16'(e);
        return {ix, drop, np, ef};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync();
        scan_sync = 1'b1;
        cyc();
        scan_sync = 1'b0;
        sync_cnt  = sync_cnt + 1;
    endtask

    // Handover monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && tvalid && tready) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL word_unexpected got %h want none", tdata);
            end else begin
                mon_exp = sb.pop_front();
                if (tdata !== mon_exp) begin
                    errors = errors + 1;
                    $display("FAIL word got %h want %h", tdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b0; diff_state_in = 1'b0; scan_sync = 1'b0; setpoint = 24'd100; tready = 1'b1;
        repeat (3) cyc();
        checks = checks + 3;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata); end
        if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_out); end
        rst = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_peak_basic();
        pulse_sync();
        repeat (130) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b0, 130 + DB, 100));
        cyc();
        for (int i = 0; i < 1 + DB; i++) begin
            cyc();
            checks++;
            if (tvalid !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", tvalid); end
        end
        cyc();
        checks++;
        if (tvalid !== 1'b1) begin errors++; $display("FAIL lat_peak got %b want 1", tvalid); end
        cyc();
        diff_state_in = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_two_rises();
        pulse_sync();
        repeat (50) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b0, 50 + DB, 100));
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (38) cyc();
        diff_state_in = 1'b1;
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (6) cyc();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL two_rises_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_no_peak_and_sat();
        pulse_sync();
        sb.push_back(mkword(sync_cnt, 1'b1, 1'b0, 0, 0));
        pulse_sync();
        cyc();
        checks++;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL np_lat_early got %b want 0", tvalid); end
        cyc();
        checks++;
        if (tvalid !== 1'b1) begin errors++; $display("FAIL np_lat got %b want 1", tvalid); end
        // two cycles of this scan already elapsed above
        setpoint = 24'd0;
        repeat (70000 - 2) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b0, 70000 + DB, 0));
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (4) cyc();
        pulse_sync();
        setpoint = 24'd100000;
        repeat (5) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b0, 5 + DB, 100000));
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (6) cyc();
        setpoint = 24'd100;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sat_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_overflow();
        tready = 1'b0;
        pulse_sync();
        repeat (10) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b0, 10 + DB, 100));
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (1 + DB) cyc();
        checks++;
        if (tvalid !== 1'b1) begin errors++; $display("FAIL ovf_first_valid got %b want 1", tvalid); end
        held = tdata;
        pulse_sync();
        repeat (5) cyc();
        diff_state_in = 1'b1;
        cyc(); cyc();
        diff_state_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (tvalid !== 1'b1 || tdata !== held) begin
                errors++;
                $display("FAIL hold_stable got %b/%h want 1/%h", tvalid, tdata, held);
            end
        end
        checks++;
        if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_out); end
        tready = 1'b1;
        cyc();
        pulse_sync();
        repeat (20) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b1, 20 + DB, 100));
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (4) cyc();
        pulse_sync();
        sb.push_back(mkword(sync_cnt, 1'b1, 1'b0, 0, 0));
        pulse_sync();
        repeat (5) cyc();
        checks += 2;
        if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_out); end
        if (sb.size() != 0) begin errors++; $display("FAIL ovf_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_coincident();
        scan_sync     = 1'b1;
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b1, 1'b0, 0, 0));
        cyc();
        scan_sync = 1'b0;
        sync_cnt  = sync_cnt + 1;
        repeat (20) cyc();
        sb.push_back(mkword(sync_cnt, 1'b1, 1'b0, 0, 0));
        pulse_sync();
        repeat (5) cyc();
        diff_state_in = 1'b0;
        cyc();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL coinc_pending got %0d want 0", sb.size()); end
    endtask

    task automatic test_reset_mid_scan();
        tready = 1'b0;
        repeat (3) cyc();
        diff_state_in = 1'b1;
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (1 + DB) cyc();
        checks++;
        if (tvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", tvalid); end
        #2;
        rst = 1'b0;
        #1;
        checks += 3;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_async_tvalid got %b want 0", tvalid); end
        if (tdata !== 32'h0) begin errors++; $display("FAIL rst_async_tdata got %h want 0", tdata); end
        if (overflow_out !== 1'b0) begin errors++; $display("FAIL rst_async_ovf got %b want 0", overflow_out); end
        sync_cnt = 0;
        tready   = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        pulse_sync();
        repeat (7) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b0, 7 + DB, 100));
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (6) cyc();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL post_reset_pending got %0d want 0", sb.size()); end
    endtask

`ifdef PEAK_ERR_DEBOUNCE_EN
    task automatic test_debounce();
        pulse_sync();
        repeat (10) cyc();
        diff_state_in = 1'b1;
        cyc();
        diff_state_in = 1'b0;
        repeat (28) cyc();
        diff_state_in = 1'b1;
        sb.push_back(mkword(sync_cnt, 1'b0, 1'b0, 40, 100));
        cyc(); cyc();
        diff_state_in = 1'b0;
        repeat (6) cyc();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL debounce_pending got %0d want 0", sb.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_peak_basic();
        test_two_rises();
        test_no_peak_and_sat();
        test_overflow();
`ifndef PEAK_ERR_DEBOUNCE_EN
        test_coincident();
`endif
        test_reset_mid_scan();
`ifdef PEAK_ERR_DEBOUNCE_EN
        test_debounce();
`endif
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_error_axis_tx.md
# peak_error_axis_tx

Converts the 1-bit negative-gradient state produced by the Savitzky–Golay differentiator into a per-scan timing error word and transmits it as an AXI4-Stream master. It sits downstream of the differentiator in the error-signal chain. Each scan period is marked by a sync pulse. The block timestamps the first peak (rising edge of the gradient state) within the scan, subtracts a setpoint, and pushes the saturated signed error toward the lock controller/DMA.

## Interface
- AXIS_TDATA_WIDTH, 32, output word width (fixed layout below; must be 32)
- CNT_WIDTH, 24, phase counter width
- ERR_WIDTH, 16, signed error field width
- clk  in  1  system clock, 125 MHz
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- diff_state_in  in  1  differentiator state: 1 = gradient ≤ 0
- scan_sync  in  1  single-cycle pulse marking the start of a scan
- setpoint  in  CNT_WIDTH  expected peak phase, unsigned, sampled at each capture
- M_AXIS_OUT_tdata  out  AXIS_TDATA_WIDTH  result word
- M_AXIS_OUT_tvalid  out  1  word valid
- M_AXIS_OUT_tready  in  1  downstream ready
- overflow_out  out  1  sticky: a result was dropped; cleared only by reset

## Operation
- Phase counter: loads 0 on a scan_sync cycle, otherwise +1 per cycle, saturating at all-ones.
- Edge qualifier: peak event = diff_state_in sampled 1 while previously sampled 0.
- FSM:
  - IDLE → ARMED on scan_sync.
  - ARMED: on a peak event, capture phase and go to CAPTURED. On scan_sync, emit a no-peak word and stay in ARMED.
  - CAPTURED: ignore peak events; go to ARMED on scan_sync.
- scan_sync and a peak event in the same cycle: scan_sync wins and the event is discarded.
- Error computation: error = phase − setpoint, computed at CNT_WIDTH+1 bits signed. Saturate to [−2^(ERR_WIDTH−1), 2^(ERR_WIDTH−1)−1].
- tdata layout:
  - [15:0] error
  - [16] no_peak (error field 0 when set)
  - [17] drop flag: ≥1 result dropped since the last accepted word
  - [31:18] scan index, 14-bit wrapping count of scan_sync pulses seen since reset
- Output holding register, one entry:
  - tvalid stays high until tvalid && tready. tdata is stable while tvalid is high without tready.
  - A new result arriving while the register is occupied and not being accepted in that cycle is dropped. The drop sets overflow_out and the pending drop flag.
  - A new result arriving in the same cycle the held word is accepted loads the register, and tvalid stays high.
  - The pending drop flag is written into the next loaded word, then cleared.
- Reset mid-scan: FSM → IDLE, held word discarded.

## Timing
- Reset values:
  - tvalid 0, tdata 0, overflow_out 0
  - FSM IDLE, counter 0, scan index 0, previous diff sample 0
- Peak latency: tvalid rises 2 cycles after the first clock edge sampling diff_state_in = 1 (capture edge, then subtract/saturate register, then output register).
- Captured phase = counter value during the cycle diff_state_in is first sampled high.
- No-peak latency: tvalid rises 2 cycles after the scan_sync edge.
- Throughput: one word per cycle when tready is held high.

## Configuration
- PEAK_ERR_DEBOUNCE_EN defined: a peak event requires diff_state_in = 1 on two consecutive samples after a 0. The captured phase is the counter value at the second sample, and latency becomes 3 cycles. A single-cycle glitch is ignored.
- Undefined: single-sample edge as described in Operation.

## Structure
- Package peak_error_pkg:
  - FSM state enum (IDLE, ARMED, CAPTURED)
  - tdata field offsets
  - ERR_MAX/ERR_MIN constants
  - saturate function
- Sub-module peak_edge_qualifier: previous-sample register plus optional debounce, emitting a 1-cycle peak pulse.

## Test plan
- Reset release, setpoint = 100, scan_sync, diff rises at phase 130, tready = 1 → one word with error = +30, no_peak = 0, scan index = 1, at latency 2.
- Two rises within one scan at phases 50 and 90 → only error = −50 emitted.
- Two scan_sync pulses with no rise → one no-peak word (bit16 = 1, error 0). Phase 70000 vs setpoint 0 → error saturates to 32767.
- tready = 0 while two results arrive → first word held stable, second dropped, overflow_out = 1. After accept, the next word has bit17 = 1 and the following word has bit17 = 0.
- scan_sync coincident with rise → no capture for either scan. Assert rst mid-CAPTURED with tvalid = 1 → tvalid 0 immediately.
- With PEAK_ERR_DEBOUNCE_EN, a 1-cycle high pulse yields nothing; a 2-cycle high at phase 40 yields error = 40 − setpoint.
